// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 / AL422B frame-FIFO read path.
//
// Contents:
//   rd_state_t   - read controller state encoding (IDLE, RST, READ, DONE)
//   RGB565 field positions inside a 16-bit pixel word
//   default frame geometry (QVGA)
//   cnt_w()      - counter width helper that never returns zero
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } rd_state_t;

  // RGB565 layout; the first byte read from the FIFO lands in [15:8].
  localparam int RGB_R_MSB   = 15;
  localparam int RGB_R_LSB   = 11;
  localparam int RGB_G_MSB   = 10;
  localparam int RGB_G_LSB   = 5;
  localparam int RGB_B_MSB   = 4;
  localparam int RGB_B_LSB   = 0;
  localparam int HI_BYTE_LSB = 8;

  localparam int H_PIX_DEF   = 320;
  localparam int V_LINES_DEF = 240;

  // $clog2 of 1 is 0, which would give zero-width vectors.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_rclk_gen.sv
// FIFO read-clock generator.
//
// Produces FIFO_RCLK by toggling every RCLK_HALF system clocks while run is
// high. A low-to-high transition is only made when allow_rise is high; when
// it is blocked the clock stays low and the phase counter freezes at its
// terminal value, so the rise happens on the first edge it is allowed.
//
// Ports:
//   SYS_CLK    in   system clock
//   RST_N      in   synchronous active-low reset
//   run        in   generator enabled; low forces FIFO_RCLK low
//   allow_rise in   permission for the next rising edge
//   FIFO_RCLK  out  registered read clock to the AL422B
//   fall       out  high in the cycle whose closing edge drives FIFO_RCLK 1->0
module ov7670_rclk_gen
  import ov7670_pkg::*;
#(
  parameter int RCLK_HALF = 1
) (
  input  logic SYS_CLK,
  input  logic RST_N,
  input  logic run,
  input  logic allow_rise,
  output logic FIFO_RCLK,
  output logic fall
);

  localparam int              PH_W    = cnt_w(RCLK_HALF);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RCLK_HALF - 1);

  logic [PH_W-1:0] phase;
  logic            phase_end;

  assign phase_end = (phase == PH_LAST);
  // Combinational so the consumer samples on the very edge that drops RCLK.
  assign fall      = run & FIFO_RCLK & phase_end;

  always_ff @(posedge SYS_CLK) begin
    if (!RST_N || !run) begin
      FIFO_RCLK <= 1'b0;
      phase     <= '0;
    end else if (phase_end) begin
      if (FIFO_RCLK) begin
        FIFO_RCLK <= 1'b0;
        phase     <= '0;
      end else if (allow_rise) begin
        FIFO_RCLK <= 1'b1;
        phase     <= '0;
      end
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/ov7670_fifo_read.sv
// Read-side controller for the AL422B frame FIFO.
//
// On each rising edge of WR_FRAME (with RD_EN high, while idle) the read
// pointer is reset, 2*H_PIX*V_LINES bytes are clocked out, paired into
// RGB565 pixels and offered on a valid/ready stream. R_IDLE is low for the
// whole frame and returns high once the last pixel has been accepted.
//
// Ports:
//   SYS_CLK    in   system clock (only clock)
//   RST_N      in   synchronous active-low reset
//   RD_EN      in   block enable, sampled only on a WR_FRAME rise
//   WR_FRAME   in   frame-written flag from the capture controller
//   FIFO_DATA  in   AL422B DO[7:0]
//   FIFO_RCLK  out  AL422B read clock
//   FIFO_RRST  out  AL422B read reset, active low
//   FIFO_OE    out  AL422B output enable, active low
//   PIX_DATA   out  RGB565 pixel, first FIFO byte in [15:8]
//   PIX_VALID  out  pixel valid
//   PIX_READY  in   downstream accept
//   PIX_SOF    out  first pixel of frame (with PIX_VALID)
//   PIX_EOL    out  last pixel of a line (with PIX_VALID)
//   R_IDLE     out  high when no frame read is in progress
module ov7670_fifo_read
  import ov7670_pkg::*;
#(
  parameter int H_PIX     = H_PIX_DEF,
  parameter int V_LINES   = V_LINES_DEF,
  parameter int RCLK_HALF = 1,
  parameter int RRST_CLKS = 2
) (
  input  logic        SYS_CLK,
  input  logic        RST_N,
  input  logic        RD_EN,
  input  logic        WR_FRAME,
  input  logic [7:0]  FIFO_DATA,
  output logic        FIFO_RCLK,
  output logic        FIFO_RRST,
  output logic        FIFO_OE,
  output logic [15:0] PIX_DATA,
  output logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic        PIX_SOF,
  output logic        PIX_EOL,
  output logic        R_IDLE
);

  localparam int COL_W  = cnt_w(H_PIX);
  localparam int ROW_W  = cnt_w(V_LINES);
  localparam int RRST_W = cnt_w(RRST_CLKS);

  rd_state_t         state_q, state_d;
  logic              wr_frame_d;
  logic [RRST_W-1:0] rrst_cnt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              byte_odd;
  logic              last_pix;
  logic [7:0]        hi_byte_p0;

  logic start, accept, fall, gen_run, allow_rise;
  logic rrst_last, col_last, row_last;

  assign start     = WR_FRAME & ~wr_frame_d & RD_EN;
  assign accept    = PIX_VALID & PIX_READY;
  assign rrst_last = (rrst_cnt == RRST_W'(RRST_CLKS - 1));
  assign col_last  = (col == COL_W'(H_PIX - 1));
  assign row_last  = (row == ROW_W'(V_LINES - 1));

  ov7670_rclk_gen #(
    .RCLK_HALF (RCLK_HALF)
  ) u_rclk_gen (
    .SYS_CLK    (SYS_CLK),
    .RST_N      (RST_N),
    .run        (gen_run),
    .allow_rise (allow_rise),
    .FIFO_RCLK  (FIFO_RCLK),
    .fall       (fall)
  );

  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    gen_run    = 1'b0;
    allow_rise = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RST;
      ST_RST: begin
        gen_run    = 1'b1;
        allow_rise = 1'b1;
        if (fall && rrst_last) state_d = ST_READ;
      end
      ST_READ: begin
        gen_run    = 1'b1;
        // A rise with byte_odd=0 fetches a high byte, which starts a new
        // pixel: hold it off while one is still pending. After the final
        // pixel this also suppresses any further RCLK edge.
        allow_rise = byte_odd | ~PIX_VALID;
        if (accept && last_pix) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      wr_frame_d <= 1'b0;
      FIFO_RRST  <= 1'b1;
      FIFO_OE    <= 1'b1;
      PIX_DATA   <= '0;
      PIX_VALID  <= 1'b0;
      PIX_SOF    <= 1'b0;
      PIX_EOL    <= 1'b0;
      R_IDLE     <= 1'b1;
      rrst_cnt   <= '0;
      col        <= '0;
      row        <= '0;
      byte_odd   <= 1'b0;
      last_pix   <= 1'b0;
    end else begin
      wr_frame_d <= WR_FRAME;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            R_IDLE    <= 1'b0;
            FIFO_RRST <= 1'b0;
            FIFO_OE   <= 1'b1;
            rrst_cnt  <= '0;
          end
        end
        ST_RST: begin
          if (fall) begin
            if (rrst_last) begin
              FIFO_RRST <= 1'b1;
              FIFO_OE   <= 1'b0;
              rrst_cnt  <= '0;
              byte_odd  <= 1'b0;
              col       <= '0;
              row       <= '0;
            end else begin
              rrst_cnt <= rrst_cnt + 1'b1;
            end
          end
        end
        ST_READ: begin
          if (accept) begin
            PIX_VALID <= 1'b0;
            PIX_SOF   <= 1'b0;
            PIX_EOL   <= 1'b0;
          end
          // Byte capture -> pixel output stage
          if (fall) begin
            if (!byte_odd) begin
              byte_odd <= 1'b1;
            end else begin
              byte_odd  <= 1'b0;
              PIX_DATA  <= {hi_byte_p0, FIFO_DATA};
              PIX_VALID <= 1'b1;
              PIX_SOF   <= (col == '0) && (row == '0);
              PIX_EOL   <= col_last;
              last_pix  <= col_last && row_last;
              if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          FIFO_OE  <= 1'b1;
          R_IDLE   <= 1'b1;
          last_pix <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // FIFO byte -> high-byte holding stage
  always_ff @(posedge SYS_CLK) begin
    if (state_q == ST_READ && fall && !byte_odd) hi_byte_p0 <= FIFO_DATA;
  end

endmodule

// File: tb/tb_ov7670_fifo_read.sv
module tb_ov7670_fifo_read;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int RH    = 1;
  localparam int RRST  = 2;
  localparam int NPIX  = H * V;
  localparam int NB    = 2 * NPIX;
  localparam int BUDGET = 3000;

  logic        SYS_CLK = 1'b0;
  logic        RST_N, RD_EN, WR_FRAME, PIX_READY;
  logic [7:0]  fifo_data = 8'h00;
  logic        FIFO_RCLK, FIFO_RRST, FIFO_OE;
  logic [15:0] PIX_DATA;
  logic        PIX_VALID, PIX_SOF, PIX_EOL, R_IDLE;

  ov7670_fifo_read #(
    .H_PIX     (H),
    .V_LINES   (V),
    .RCLK_HALF (RH),
    .RRST_CLKS (RRST)
  ) dut (
    .SYS_CLK   (SYS_CLK),
    .RST_N     (RST_N),
    .RD_EN     (RD_EN),
    .WR_FRAME  (WR_FRAME),
    .FIFO_DATA (fifo_data),
    .FIFO_RCLK (FIFO_RCLK),
    .FIFO_RRST (FIFO_RRST),
    .FIFO_OE   (FIFO_OE),
    .PIX_DATA  (PIX_DATA),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .PIX_SOF   (PIX_SOF),
    .PIX_EOL   (PIX_EOL),
    .R_IDLE    (R_IDLE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // AL422B read port: a rise with RRST low rewinds; otherwise the byte at
  // the read pointer appears on DO and the pointer advances.
  logic [7:0] mem [NB];
  int rptr = 0;
  int rise_cnt = 0;
  int rrst_rises = 0;
  always @(posedge FIFO_RCLK) begin
    rise_cnt++;
    if (!FIFO_RRST) begin
      rrst_rises++;
      rptr = 0;
    end else begin
      fifo_data <= mem[rptr % NB];
      rptr = rptr + 1;
    end
  end

  // Stream monitor
  logic [17:0] got_q [$];
  logic [17:0] exp_q [$];
  int          acc_cyc [$];
  int          cyc = 0;
  int          rrst_low_cyc = 0;
  int          stab_bad = 0;
  logic        prev_pend = 1'b0;
  logic [17:0] prev_word = '0;

  always @(posedge SYS_CLK) cyc++;

  always @(negedge SYS_CLK) begin
    if (!FIFO_RRST) rrst_low_cyc++;
    if (RST_N) begin
      if (prev_pend && {PIX_SOF, PIX_EOL, PIX_DATA} !== prev_word) stab_bad++;
      if (PIX_VALID && PIX_READY) begin
        got_q.push_back({PIX_SOF, PIX_EOL, PIX_DATA});
        acc_cyc.push_back(cyc);
      end
      prev_pend = PIX_VALID && !PIX_READY;
    end else begin
      prev_pend = 1'b0;
    end
    prev_word = {PIX_SOF, PIX_EOL, PIX_DATA};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  // Expected stream: byte pairs in FIFO order, SOF on pixel 0, EOL at line ends.
  task automatic build_exp();
    exp_q.delete();
    for (int p = 0; p < NPIX; p++)
      exp_q.push_back({(p == 0), ((p % H) == H - 1), mem[2*p], mem[2*p+1]});
  endtask

  task automatic fill_mem(input bit incr);
    for (int i = 0; i < NB; i++) mem[i] = incr ? 8'(i) : 8'($urandom);
    build_exp();
  endtask

  task automatic clear_mon();
    got_q.delete();
    acc_cyc.delete();
    rise_cnt = 0;
    rrst_rises = 0;
    rrst_low_cyc = 0;
  endtask

  task automatic check_frame(input string tag, input int base);
    chk({tag, "_count"}, got_q.size(), base + NPIX);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s_pix%0d", tag, i),
          (base + i < got_q.size()) ? {14'd0, got_q[base + i]} : 32'hFFFF_FFFF,
          {14'd0, exp_q[i]});
  endtask

  task automatic start_frame(input string tag);
    WR_FRAME = 1'b0;
    step(1);
    WR_FRAME = 1'b1;
    chk({tag, "_idle_pre"}, R_IDLE, 1);
    step(1);
    chk({tag, "_idle_low"}, R_IDLE, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!R_IDLE && k < BUDGET) begin
      step(1);
      k++;
    end
    chk({tag, "_done"}, R_IDLE, 1);
  endtask

  initial begin
    #(BUDGET * 200);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, r0;
    logic [17:0] w0;

    RST_N = 1'b0; RD_EN = 1'b0; WR_FRAME = 1'b0; PIX_READY = 1'b0;
    for (int i = 0; i < NB; i++) mem[i] = 8'h00;

    // Reset state
    step(3);
    chk("rst_rclk", FIFO_RCLK, 0);
    chk("rst_rrst", FIFO_RRST, 1);
    chk("rst_oe", FIFO_OE, 1);
    chk("rst_idle", R_IDLE, 1);
    chk("rst_valid", PIX_VALID, 0);
    chk("rst_data", PIX_DATA, 0);
    RST_N = 1'b1;
    step(2);

    // Disabled: a WR_FRAME rise with RD_EN low is ignored
    clear_mon();
    WR_FRAME = 1'b1;
    step(20);
    chk("dis_rises", rise_cnt, 0);
    chk("dis_idle", R_IDLE, 1);
    WR_FRAME = 1'b0;
    step(2);

    // Full frame, incrementing bytes, READY high; RD_EN dropped mid-frame
    fill_mem(1'b1);
    clear_mon();
    RD_EN = 1'b1;
    PIX_READY = 1'b1;
    start_frame("f1");
    step(10);
    RD_EN = 1'b0;
    wait_idle("f1");
    check_frame("f1", 0);
    chk("f1_rises", rise_cnt, RRST + 2 * NPIX);
    chk("f1_rrst_rises", rrst_rises, RRST);
    chk("f1_rrst_cycles", rrst_low_cyc, RRST * 2 * RH);
    chk("f1_oe", FIFO_OE, 1);
    chk("f1_rclk", FIFO_RCLK, 0);
    chk("f1_thruput", (acc_cyc.size() >= NPIX) ? acc_cyc[NPIX-1] - acc_cyc[0] : -1,
        (NPIX - 1) * (4 * RH + 1));
    // WR_FRAME still high: no retrigger
    step(30);
    chk("f1_noretrig_rises", rise_cnt, RRST + 2 * NPIX);
    chk("f1_noretrig_idle", R_IDLE, 1);
    chk("f1_noretrig_pix", got_q.size(), NPIX);

    // Back-pressure: stall 10 cycles while pixel 2 is pending
    fill_mem(1'b0);
    clear_mon();
    RD_EN = 1'b1;
    PIX_READY = 1'b1;
    start_frame("bp");
    k = 0;
    while (got_q.size() < 2 && k < BUDGET) begin step(1); k++; end
    PIX_READY = 1'b0;
    k = 0;
    while (!PIX_VALID && k < 100) begin step(1); k++; end
    chk("bp_pending", PIX_VALID, 1);
    r0 = rise_cnt;
    w0 = {PIX_SOF, PIX_EOL, PIX_DATA};
    step(10);
    chk("bp_no_rise", rise_cnt, r0);
    chk("bp_hold", {PIX_SOF, PIX_EOL, PIX_DATA}, w0);
    chk("bp_hold_valid", PIX_VALID, 1);
    PIX_READY = 1'b1;
    wait_idle("bp");
    check_frame("bp", 0);
    chk("bp_rises", rise_cnt, RRST + 2 * NPIX);

    // Random READY with a WR_FRAME toggle mid-read
    fill_mem(1'b0);
    clear_mon();
    start_frame("rnd");
    k = 0;
    while (!R_IDLE && k < BUDGET) begin
      PIX_READY = ($urandom_range(0, 2) != 0);
      if (k == 15) WR_FRAME = 1'b0;
      if (k == 17) WR_FRAME = 1'b1;
      step(1);
      k++;
    end
    PIX_READY = 1'b1;
    chk("rnd_done", R_IDLE, 1);
    step(20);
    check_frame("rnd", 0);
    chk("rnd_rises", rise_cnt, RRST + 2 * NPIX);

    // Reset while pixel 5 is pending, then a fresh frame
    fill_mem(1'b0);
    clear_mon();
    start_frame("mr");
    k = 0;
    while (got_q.size() < 5 && k < BUDGET) begin step(1); k++; end
    PIX_READY = 1'b0;
    k = 0;
    while (!PIX_VALID && k < 100) begin step(1); k++; end
    chk("mr_pending", PIX_VALID, 1);
    WR_FRAME = 1'b0;
    RST_N = 1'b0;
    step(1);
    chk("mr_rclk", FIFO_RCLK, 0);
    chk("mr_rrst", FIFO_RRST, 1);
    chk("mr_oe", FIFO_OE, 1);
    chk("mr_idle", R_IDLE, 1);
    chk("mr_outs", {PIX_VALID, PIX_SOF, PIX_EOL, PIX_DATA}, 0);
    RST_N = 1'b1;
    PIX_READY = 1'b1;
    step(3);
    fill_mem(1'b0);
    clear_mon();
    start_frame("mr2");
    wait_idle("mr2");
    check_frame("mr2", 0);
    chk("mr2_rrst_rises", rrst_rises, RRST);
    chk("mr2_rises", rise_cnt, RRST + 2 * NPIX);

    // Writer handshake: writer holds its WAIT state until R_IDLE returns,
    // then immediately captures and signals the next frame.
    WR_FRAME = 1'b0;
    step(1);
    for (int f = 0; f < 2; f++) begin
      fill_mem(1'b0);
      clear_mon();
      WR_FRAME = 1'b1;
      step(1);
      chk($sformatf("wr%0d_busy", f), R_IDLE, 0);
      wait_idle($sformatf("wr%0d", f));
      check_frame($sformatf("wr%0d", f), 0);
      WR_FRAME = 1'b0;
      step(1);
    end

    chk("stability", stab_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
